serial_parity_framer: RTL and testbench

// - Upstream stage of the serial even/odd parity checker.
// - Accepts a parallel word over a valid/ready handshake and shifts it out on a 1-bit serial line, LSB first.
// - Appends one generated parity bit after the data bits.
// - The downstream checker consumes x on every cycle where x_valid=1. It sees DATA_W data bits followed by the parity bit.

---
 rtl/parity_pkg.sv | 13 +
 rtl/serial_parity_framer.sv | 113 +++++++++++
 tb/tb_serial_parity_framer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity framer and its downstream checker.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } framer_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_framer.sv
// Serialises a parallel word LSB first over a valid/ready handshake and
// appends one generated even/odd parity bit after the data bits.
module serial_parity_framer
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x,
    output logic              x_valid,
    output logic              x_first,
    output logic              x_last,
    output logic              busy
);

    localparam int unsigned     CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    framer_state_t     state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    logic              accept;

    logic x_d, x_valid_d, x_first_d, x_last_d, busy_d, din_ready_d;

    assign accept = din_valid & din_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        case (state_q)
            IDLE, PARITY: begin
                if (accept) begin
                    state_d = DATA;
                    shreg_d = din;
                    cnt_d   = '0;
                    par_d   = PARITY_ODD;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                shreg_d = shreg_q >> 1;
                par_d   = par_q ^ shreg_q[0];
                if (cnt_q == CNT_LAST) begin
                    // Counter holds at its terminal value rather than wrapping.
                    state_d = PARITY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_comb begin
        x_d         = 1'b0;
        x_valid_d   = 1'b0;
        x_first_d   = 1'b0;
        x_last_d    = 1'b0;
        busy_d      = (state_d != IDLE);
        din_ready_d = (state_d != DATA);
        case (state_d)
            DATA: begin
                x_d       = shreg_d[0];
                x_valid_d = 1'b1;
                x_first_d = (cnt_d == '0);
            end
            PARITY: begin
                x_d       = par_d;
                x_valid_d = 1'b1;
                x_last_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            x_first   <= 1'b0;
            x_last    <= 1'b0;
            busy      <= 1'b0;
            din_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            x         <= x_d;
            x_valid   <= x_valid_d;
            x_first   <= x_first_d;
            x_last    <= x_last_d;
            busy      <= busy_d;
            din_ready <= din_ready_d;
        end
    end

endmodule

// File: tb/tb_serial_parity_framer.sv
// Bench for serial_parity_framer: even and odd instances share stimulus and are
// checked every cycle against a queue-of-frames reference model.
module tb_serial_parity_framer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         rdy_e, x_e, xv_e, xf_e, xl_e, busy_e;
    logic         rdy_o, x_o, xv_o, xf_o, xl_o, busy_o;

    always #5 clk = ~clk;

    serial_parity_framer #(.DATA_W(W), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_e),
        .x(x_e), .x_valid(xv_e), .x_first(xf_e), .x_last(xl_e), .busy(busy_e)
    );

    serial_parity_framer #(.DATA_W(W), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_o),
        .x(x_o), .x_valid(xv_o), .x_first(xf_o), .x_last(xl_o), .busy(busy_o)
    );

    // One entry per output cycle still owed by the frames accepted so far.
    typedef struct packed {
        logic xe;
        logic xo;
        logic first;
        logic last;
    } ent_t;

    ent_t q[$];
    bit   rdy_en;
    bit   last_acc;
    int   n_cmp, n_bad;
    int   run, last_run;
    logic par_e, par_o;

    function automatic bit exp_ready();
        return rdy_en && (q.size() <= 1);
    endfunction

    function automatic void push_frame(input logic [W-1:0] w);
        ent_t e;
        for (int i = 0; i < W; i++) begin
            e = '{xe: w[i], xo: w[i], first: (i == 0), last: 1'b0};
            q.push_back(e);
        end
        e = '{xe: ^w, xo: ~(^w), first: 1'b0, last: 1'b1};
        q.push_back(e);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        ent_t e;
        bit   act;
        act = (q.size() > 0);
        e   = act ? q[0] : '0;
        check("din_ready_e", rdy_e, exp_ready());
        check("din_ready_o", rdy_o, exp_ready());
        check("x_valid_e", xv_e, act);
        check("x_valid_o", xv_o, act);
        check("busy_e", busy_e, act);
        check("busy_o", busy_o, act);
        check("x_e", x_e, e.xe);
        check("x_o", x_o, e.xo);
        check("x_first_e", xf_e, e.first);
        check("x_first_o", xf_o, e.first);
        check("x_last_e", xl_e, e.last);
        check("x_last_o", xl_o, e.last);
        if (xl_e) par_e = x_e;
        if (xl_o) par_o = x_o;
        if (xv_e) run++;
        else if (run > 0) begin
            last_run = run;
            run      = 0;
        end
    endtask

    task automatic tick();
        bit acc;
        acc = din_valid && rst_n && exp_ready();
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            rdy_en   = 1'b0;
            last_acc = 1'b0;
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (acc) push_frame(din);
            rdy_en   = 1'b1;
            last_acc = acc;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [W-1:0] w);
        int n;
        n         = 0;
        din       = w;
        din_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 30);
        check("accept_seen", last_acc, 1'b1);
        din_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        q.delete();
        rdy_en = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        int k;
        n_cmp = 0; n_bad = 0; run = 0; last_run = 0;
        par_e = 1'b0; par_o = 1'b0;
        rst_n = 1'b1; din_valid = 1'b0; din = W'($urandom);
        #2;
        assert_reset();
        repeat (2) tick();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after release; din wanders but is never accepted.
        for (int i = 0; i < 10; i++) begin
            din = W'($urandom);
            tick();
        end

        send(8'hA5);
        drain(12);
        check("par_a5_even", par_e, 1'b0);

        send(8'h07);
        drain(12);
        check("par_07_even", par_e, 1'b1);
        check("par_07_odd", par_o, 1'b0);

        // Back-to-back with din_valid held; second accept must land in the parity cycle.
        din = 8'hFF; din_valid = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!last_acc && k < 30);
        din = 8'h01;
        k = 0;
        do begin tick(); k++; end while (!last_acc && k < 30);
        check_int("b2b_accept_gap", k, W + 1);
        check("par_ff_even", par_e, 1'b0);
        din_valid = 1'b0;
        drain(12);
        check_int("b2b_run_len", last_run, 2 * (W + 1));
        check("par_01_even", par_e, 1'b1);
        check("par_01_odd", par_o, 1'b0);

        // Reset while the 4th bit of 8'h3C is on the line.
        par_e = 1'b0;
        send(8'h3C);
        drain(3);
        check("pre_reset_valid", xv_e, 1'b1);
        assert_reset();
        check("abort_no_last", xl_e, 1'b0);
        check("abort_no_parity", par_e, 1'b0);
        drain(2);
        rst_n = 1'b1;
        drain(2);
        send(8'h80);
        drain(12);
        check("par_80_even", par_e, 1'b1);

        // din_valid pulsed mid-frame with different data must be ignored.
        send(8'h5A);
        drain(2);
        din = 8'hC3; din_valid = 1'b1;
        tick();
        check("mid_frame_no_accept", last_acc, 1'b0);
        din_valid = 1'b0;
        drain(12);

        // Randomised traffic; din_valid and din change every cycle.
        for (int i = 0; i < 300; i++) begin
            din       = W'($urandom);
            din_valid = ($urandom_range(0, 2) != 0);
            tick();
        end
        din_valid = 1'b0;
        drain(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
